// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter that lets NREQ producers share the
//               write port of one coefficient FIFO, with fifofull back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ      = 2,
    parameter int DATAWIDTH = 13,
    parameter int ADDRBIT   = 4,
    parameter int BURST     = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NREQ-1:0]                             req_valid,
    input  logic [NREQ*DATAWIDTH-1:0]                   req_data,
    output logic [NREQ-1:0]                             req_ready,
    input  logic                                        fifofull,
    output logic                                        fifowr,
    output logic [DATAWIDTH-1:0]                        fifo_data_in,
    output logic                                        busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  grant_id
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW  = $clog2(BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    generate
        if (NREQ < 2 || BURST < 1 || ADDRBIT < 1 || DATAWIDTH < 1) begin : g_param_check
            $error("fifo_wr_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [0:0]           r_state, w_state_nxt;
    logic [IDW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [IDW-1:0]       r_owner, w_owner_nxt;
    logic [BW-1:0]        r_beat_cnt, w_beat_cnt_nxt;
    logic [IDW-1:0]       w_pick, w_idx, w_owner_inc;
    logic                 w_found, w_owner_valid, w_xfer;
    logic [DATAWIDTH-1:0] w_lane_data [NREQ];

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_lane_data[g] = req_data[g*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    assign w_owner_valid = req_valid[r_owner];
    assign w_xfer        = (r_state == S_OWN) && w_owner_valid && !fifofull;
    assign w_owner_inc   = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign grant_id      = r_owner;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit modulo so any NREQ works.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        req_ready      = '0;
        fifowr         = 1'b0;
        fifo_data_in   = '0;
        busy           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = S_OWN;
                end
            end
            S_OWN: begin
                busy               = 1'b1;
                req_ready[r_owner] = ~fifofull;
                fifowr             = w_xfer;
                if (w_xfer) begin
                    fifo_data_in   = w_lane_data[r_owner];
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
                // A stalled owner keeps the grant; only a finished burst or an
                // idle owner hands the port on.
                if ((w_xfer && (r_beat_cnt == BW'(BURST - 1))) || !w_owner_valid) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter with counting
//               producers and a simple 15-entry FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid;
    logic [2*DW-1:0] req_data;
    logic [1:0]    req_ready;
    logic          fifofull;
    logic          fifowr;
    logic [DW-1:0] fifo_data_in;
    logic          busy;
    logic [0:0]    grant_id;

    logic [1:0]    mask       = 2'b00;
    logic          full_force = 1'b0;
    logic          model_en   = 1'b0;
    int            lim0       = 0;
    int            lim1       = 0;
    logic [7:0]    sent0      = 8'd0;
    logic [7:0]    sent1      = 8'd0;
    int            wr_total   = 0;
    int            base       = 0;
    logic [DW-1:0] wlog [256];

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .NREQ(2), .DATAWIDTH(DW), .ADDRBIT(4), .BURST(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifofull(fifofull), .fifowr(fifowr), .fifo_data_in(fifo_data_in),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Producers: lane i emits {i+1, word count} and advances on handshake.
    assign req_valid = {mask[1] & (int'(sent1) < lim1), mask[0] & (int'(sent0) < lim0)};
    assign req_data  = {{5'd2, sent1}, {5'd1, sent0}};
    // FIFO model: ADDRBIT=4 leaves 15 usable entries.
    assign fifofull  = full_force | (model_en && ((wr_total - base) >= 15));

    always @(posedge clk) begin
        if (req_valid[0] && req_ready[0]) sent0 <= sent0 + 8'd1;
        if (req_valid[1] && req_ready[1]) sent1 <= sent1 + 8'd1;
        if (fifowr) begin
            wlog[wr_total[7:0]] <= fifo_data_in;
            wr_total <= wr_total + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wr"}, 32'(fifowr), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
        chk({tag, "_data"}, 32'(fifo_data_in), 32'd0);
    endtask

    logic [DW-1:0] e2_dat [11];
    logic          e2_wr  [11];
    logic [1:0]    e2_rdy [11];
    logic [DW-1:0] e5_dat [15];
    int            duty;
    int            snap;

    initial begin
        e2_dat = '{13'h100, 13'h101, 13'h102, 13'h103, 13'h000,
                   13'h200, 13'h201, 13'h202, 13'h203, 13'h000, 13'h104};
        e2_wr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        e2_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                   2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        e5_dat = '{13'h206, 13'h207, 13'h208, 13'h209,
                   13'h108, 13'h109, 13'h10A, 13'h10B,
                   13'h20A, 13'h20B, 13'h20C, 13'h20D,
                   13'h10C, 13'h10D, 13'h10E};

        // 1: reset with random requests, then first grant goes to req0
        lim0 = 100;
        lim1 = 100;
        for (int i = 0; i < 3; i++) begin
            tick();
            mask = 2'($urandom);
            #1;
            chk_idle("rst_hold");
            chk("rst_gid", 32'(grant_id), 32'd0);
        end
        mask = 2'b11;
        rst  = 1'b1;
        #1;
        chk("rel_busy", 32'(busy), 32'd0);
        tick();
        #1;
        chk("grant0_busy", 32'(busy), 32'd1);
        chk("grant0_gid", 32'(grant_id), 32'd0);

        // 2: both always valid -> 4 from req0, bubble, 4 from req1, bubble, req0
        duty = 0;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) begin
                tick();
                #1;
            end
            chk($sformatf("rr_wr%0d", c), 32'(fifowr), 32'(e2_wr[c]));
            chk($sformatf("rr_dat%0d", c), 32'(fifo_data_in), 32'(e2_dat[c]));
            chk($sformatf("rr_rdy%0d", c), 32'(req_ready), 32'(e2_rdy[c]));
            if (c < 10 && fifowr) duty++;
        end
        chk("rr_duty", 32'(duty), 32'd8);

        // 3: req0 drops, req1 alone sends 2 words then drops
        lim0 = int'(sent0);
        lim1 = int'(sent1) + 2;
        #1;
        chk("drop_wr", 32'(fifowr), 32'd0);
        tick(); #1;
        chk("er_bubble", 32'(busy), 32'd0);
        tick(); #1;
        chk("er_gid", 32'(grant_id), 32'd1);
        chk("er_dat0", 32'(fifo_data_in), 32'h204);
        tick(); #1;
        chk("er_dat1", 32'(fifo_data_in), 32'h205);
        tick(); #1;
        chk("er_novalid_wr", 32'(fifowr), 32'd0);
        chk("er_novalid_busy", 32'(busy), 32'd1);
        tick();
        lim0 = int'(sent0) + 4;
        lim1 = int'(sent1) + 4;
        #1;
        chk("er_idle_busy", 32'(busy), 32'd0);

        // 4: rr_ptr back at 0 -> req0; stall at beat 2 for 5 cycles
        tick(); #1;
        chk("st_gid", 32'(grant_id), 32'd0);
        chk("st_dat0", 32'(fifo_data_in), 32'h104);
        tick(); #1;
        chk("st_dat1", 32'(fifo_data_in), 32'h105);
        tick();
        full_force = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #1;
            chk($sformatf("st_wr%0d", c), 32'(fifowr), 32'd0);
            chk($sformatf("st_rdy%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("st_busy%0d", c), 32'(busy), 32'd1);
            chk($sformatf("st_gid%0d", c), 32'(grant_id), 32'd0);
        end
        tick();
        full_force = 1'b0;
        #1;
        chk("st_resume_rdy", 32'(req_ready), 32'd1);
        chk("st_dat2", 32'(fifo_data_in), 32'h106);
        tick(); #1;
        chk("st_dat3", 32'(fifo_data_in), 32'h107);
        tick();
        lim0 = int'(sent0);
        lim1 = int'(sent1);
        #1;
        chk("st_bubble", 32'(busy), 32'd0);
        tick();

        // 5: FIFO model fills after 15 writes; order must follow grant order
        base     = wr_total;
        model_en = 1'b1;
        lim0     = int'(sent0) + 100;
        lim1     = int'(sent1) + 100;
        for (int c = 0; c < 25; c++) tick();
        #1;
        chk("ff_count", 32'(wr_total - base), 32'd15);
        chk("ff_full", 32'(fifofull), 32'd1);
        chk("ff_wr", 32'(fifowr), 32'd0);
        chk("ff_rdy", 32'(req_ready), 32'd0);
        chk("ff_hold_gid", 32'(grant_id), 32'd0);
        for (int k = 0; k < 15; k++)
            chk($sformatf("ff_order%0d", k), 32'(wlog[8'(base + k)]), 32'(e5_dat[k]));

        // 6: async reset at beat 1 of a req1 burst
        model_en = 1'b0;
        lim0     = int'(sent0);
        lim1     = int'(sent1);
        #1;
        chk("ar_release_wr", 32'(fifowr), 32'd0);
        tick();
        snap = wr_total;
        lim0 = int'(sent0) + 10;
        lim1 = int'(sent1) + 10;
        tick(); #1;
        chk("ar_gid", 32'(grant_id), 32'd1);
        chk("ar_dat0", 32'(fifo_data_in), 32'h20E);
        tick();
        rst = 1'b0;
        #1;
        chk_idle("ar_clear");
        tick(); #1;
        chk("ar_nowrite", 32'(wr_total - snap), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_rel_busy", 32'(busy), 32'd0);
        tick(); #1;
        chk("ar_post_gid", 32'(grant_id), 32'd0);
        chk("ar_post_wr", 32'(fifowr), 32'd1);
        chk("ar_post_dat", 32'(fifo_data_in), 32'h10F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
